// File: rtl/hlsm_launcher.sv
// Start/Done launcher for HLSM-class datapath cores: accepts operand bundles on a
// valid/ready stream, runs one core operation under a timeout, returns k/l downstream.
module hlsm_launcher #(
    parameter int W       = 16,
    parameter int TIMEOUT = 64
) (
    input  logic                Clk,
    input  logic                Rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic signed [W-1:0] in_a,
    input  logic signed [W-1:0] in_b,
    input  logic signed [W-1:0] in_c,
    input  logic signed [W-1:0] in_d,
    input  logic signed [W-1:0] in_e,
    input  logic signed [W-1:0] in_f,
    input  logic signed [W-1:0] in_g,
    output logic                out_valid,
    input  logic                out_ready,
    output logic signed [W-1:0] out_k,
    output logic signed [W-1:0] out_l,
    output logic                out_err,
    output logic                core_Rst,
    output logic                core_Start,
    input  logic                core_Done,
    output logic signed [W-1:0] core_a,
    output logic signed [W-1:0] core_b,
    output logic signed [W-1:0] core_c,
    output logic signed [W-1:0] core_d,
    output logic signed [W-1:0] core_e,
    output logic signed [W-1:0] core_f,
    output logic signed [W-1:0] core_g,
    input  logic signed [W-1:0] core_k,
    input  logic signed [W-1:0] core_l,
    output logic                busy,
    output logic [15:0]         op_count
);

    localparam int            TW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_START,
        S_WAIT,
        S_RESULT
    } state_t;

    state_t              r_state;
    logic signed [W-1:0] r_a, r_b, r_c, r_d, r_e, r_f, r_g;
    logic signed [W-1:0] r_out_k, r_out_l;
    logic                r_out_err;
    logic                r_out_valid;
    logic                r_in_ready;
    logic                r_busy;
    logic                r_core_start;
    logic [15:0]         r_op_count;
    logic [TW-1:0]       r_tmo;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state      <= S_IDLE;
            r_a          <= '0;
            r_b          <= '0;
            r_c          <= '0;
            r_d          <= '0;
            r_e          <= '0;
            r_f          <= '0;
            r_g          <= '0;
            r_out_k      <= '0;
            r_out_l      <= '0;
            r_out_err    <= 1'b0;
            r_out_valid  <= 1'b0;
            r_in_ready   <= 1'b1;
            r_busy       <= 1'b0;
            r_core_start <= 1'b0;
            r_op_count   <= '0;
            r_tmo        <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid && r_in_ready) begin
                        r_a        <= in_a;
                        r_b        <= in_b;
                        r_c        <= in_c;
                        r_d        <= in_d;
                        r_e        <= in_e;
                        r_f        <= in_f;
                        r_g        <= in_g;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= S_CLR;
                    end
                end
                S_CLR: begin
                    // Start is registered, so it is raised on the edge that enters START.
                    r_core_start <= 1'b1;
                    r_state      <= S_START;
                end
                S_START: begin
                    r_core_start <= 1'b0;
                    r_tmo        <= '0;
                    r_state      <= S_WAIT;
                end
                S_WAIT: begin
                    if (core_Done) begin
                        r_out_k     <= core_k;
                        r_out_l     <= core_l;
                        r_out_err   <= 1'b0;
                        r_out_valid <= 1'b1;
                        r_op_count  <= r_op_count + 16'd1;
                        r_state     <= S_RESULT;
                    end else if (r_tmo == TMO_LAST) begin
                        r_out_k     <= '0;
                        r_out_l     <= '0;
                        r_out_err   <= 1'b1;
                        r_out_valid <= 1'b1;
                        r_op_count  <= r_op_count + 16'd1;
                        r_state     <= S_RESULT;
                    end else begin
                        r_tmo <= r_tmo + 1'b1;
                    end
                end
                S_RESULT: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_out_valid  <= 1'b0;
                    r_in_ready   <= 1'b1;
                    r_busy       <= 1'b0;
                    r_core_start <= 1'b0;
                    r_state      <= S_IDLE;
                end
            endcase
        end
    end

    // NOTE: core_Rst is combinational so the core is held in reset during our own Rst cycle too.
    assign core_Rst   = Rst | (r_state == S_CLR);
    assign core_Start = r_core_start;

    assign core_a = r_a;
    assign core_b = r_b;
    assign core_c = r_c;
    assign core_d = r_d;
    assign core_e = r_e;
    assign core_f = r_f;
    assign core_g = r_g;

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_k     = r_out_k;
    assign out_l     = r_out_l;
    assign out_err   = r_out_err;
    assign busy      = r_busy;
    assign op_count  = r_op_count;

endmodule

// File: tb/tb_hlsm_launcher.sv
// Directed bench for hlsm_launcher against a behavioural HLSM6-timed core
// (k = b + g + d - a, l = a + b*c, Done 5 edges after Start is sampled).
module tb_hlsm_launcher;

    localparam int W       = 16;
    localparam int TIMEOUT = 16;

    logic                clk = 1'b0;
    logic                rst;
    logic                in_valid;
    logic                in_ready;
    logic signed [W-1:0] in_a, in_b, in_c, in_d, in_e, in_f, in_g;
    logic                out_valid;
    logic                out_ready;
    logic signed [W-1:0] out_k, out_l;
    logic                out_err;
    logic                core_rst;
    logic                core_start;
    logic                core_done;
    logic signed [W-1:0] core_a, core_b, core_c, core_d, core_e, core_f, core_g;
    logic signed [W-1:0] core_k, core_l;
    logic                busy;
    logic [15:0]         op_count;

    logic                core_dead;
    logic [4:0]          stub_sr;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    hlsm_launcher #(.W(W), .TIMEOUT(TIMEOUT)) dut (
        .Clk       (clk),
        .Rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_c      (in_c),
        .in_d      (in_d),
        .in_e      (in_e),
        .in_f      (in_f),
        .in_g      (in_g),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_k     (out_k),
        .out_l     (out_l),
        .out_err   (out_err),
        .core_Rst  (core_rst),
        .core_Start(core_start),
        .core_Done (core_done),
        .core_a    (core_a),
        .core_b    (core_b),
        .core_c    (core_c),
        .core_d    (core_d),
        .core_e    (core_e),
        .core_f    (core_f),
        .core_g    (core_g),
        .core_k    (core_k),
        .core_l    (core_l),
        .busy      (busy),
        .op_count  (op_count)
    );

    // Core model: sticky Done, cleared only by core reset; core_dead never completes.
    always @(posedge clk) begin
        if (core_rst) begin
            stub_sr   <= '0;
            core_done <= 1'b0;
            core_k    <= '0;
            core_l    <= '0;
        end else begin
            stub_sr <= {stub_sr[3:0], core_start & ~core_dead};
            if (stub_sr[4]) begin
                core_done <= 1'b1;
                core_k    <= core_b + core_g + core_d - core_a;
                core_l    <= core_a + core_b * core_c;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int a, b, c, d, e, f, g);
        in_a = W'(a);
        in_b = W'(b);
        in_c = W'(c);
        in_d = W'(d);
        in_e = W'(e);
        in_f = W'(f);
        in_g = W'(g);
    endtask

    // Handshake on the next edge (launcher must be idle).
    task automatic send(input int a, b, c, d, e, f, g);
        load(a, b, c, d, e, f, g);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(input string tag, input int max_cycles);
        int n = 0;
        while (!out_valid && n < max_cycles) begin
            step();
            n++;
        end
        check(tag, 32'(out_valid), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        core_dead = 1'b0;
        load(0, 0, 0, 0, 0, 0, 0);
        #1;
        check("core_rst_in_reset", 32'(core_rst), 32'd1);
        step();
        step();
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_op_count", 32'(op_count), 32'd0);
        check("rst_core_start", 32'(core_start), 32'd0);
        check("rst_out_k", 32'(out_k), 32'd0);
        check("rst_out_err", 32'(out_err), 32'd0);
        check("rst_core_a", 32'(core_a), 32'd0);
        rst = 1'b0;
        step();

        // Rst while waiting for Done: aborted op is discarded and not counted.
        send(2, 3, 4, 5, 2, 100, 7);
        step();
        step();
        step();
        check("abort_busy_before", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        check("abort_core_rst", 32'(core_rst), 32'd1);
        step();
        rst = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_in_ready", 32'(in_ready), 32'd1);
        check("abort_op_count", 32'(op_count), 32'd0);
        step();

        // Single op: handshake at edge h, Done after h+7, result after h+8.
        send(2, 3, 4, 5, 2, 100, 7);
        check("op1_clr_core_rst", 32'(core_rst), 32'd1);
        check("op1_clr_in_ready", 32'(in_ready), 32'd0);
        check("op1_clr_core_start", 32'(core_start), 32'd0);
        check("op1_core_a", 32'(core_a), 32'd2);
        check("op1_core_g", 32'(core_g), 32'd7);
        step();
        check("op1_start_pulse", 32'(core_start), 32'd1);
        check("op1_start_core_rst", 32'(core_rst), 32'd0);
        step();
        check("op1_wait_start_low", 32'(core_start), 32'd0);
        repeat (4) step();
        check("op1_done_h6", 32'(core_done), 32'd0);
        step();
        check("op1_done_h7", 32'(core_done), 32'd1);
        check("op1_valid_h7", 32'(out_valid), 32'd0);
        step();
        check("op1_valid_h8", 32'(out_valid), 32'd1);
        check("op1_k", 32'(out_k), 32'd13);
        check("op1_l", 32'(out_l), 32'd14);
        check("op1_err", 32'(out_err), 32'd0);
        check("op1_op_count", 32'(op_count), 32'd1);

        // Backpressure: result held for 20 cycles with out_ready low.
        for (int i = 0; i < 20; i++) begin
            step();
            check("bp_valid", 32'(out_valid), 32'd1);
            check("bp_k", 32'(out_k), 32'd13);
            check("bp_l", 32'(out_l), 32'd14);
            check("bp_ready_start", {30'd0, in_ready, core_start}, 32'd0);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("bp_release_valid", 32'(out_valid), 32'd0);
        check("bp_release_in_ready", 32'(in_ready), 32'd1);
        check("bp_release_busy", 32'(busy), 32'd0);

        // Back-to-back with out_ready tied high.
        out_ready = 1'b1;
        send(2, 3, 4, 5, 2, 100, 7);
        check("b2b1_clr_core_rst", 32'(core_rst), 32'd1);
        repeat (8) step();
        check("b2b1_valid", 32'(out_valid), 32'd1);
        check("b2b1_k", 32'(out_k), 32'd13);
        load(-6, 2, 1, 1, -1, -9, 2);
        in_valid = 1'b1;
        step();
        check("b2b_idle_valid", 32'(out_valid), 32'd0);
        check("b2b_idle_in_ready", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        check("b2b2_clr_core_rst", 32'(core_rst), 32'd1);
        check("b2b2_in_ready", 32'(in_ready), 32'd0);
        check("b2b2_core_a", 32'(core_a), -32'sd6);
        step();
        check("b2b2_start_pulse", 32'(core_start), 32'd1);
        repeat (7) step();
        check("b2b2_valid", 32'(out_valid), 32'd1);
        check("b2b2_k", 32'(out_k), 32'd11);
        check("b2b2_l", 32'(out_l), -32'sd4);
        check("b2b2_err", 32'(out_err), 32'd0);
        check("b2b2_op_count", 32'(op_count), 32'd3);
        step();
        check("b2b2_one_cycle", 32'(out_valid), 32'd0);
        out_ready = 1'b0;

        // Timeout: dead core, result at handshake + TIMEOUT + 2.
        core_dead = 1'b1;
        send(1, 2, 3, 4, 5, 6, 7);
        repeat (TIMEOUT + 1) step();
        check("tmo_valid_early", 32'(out_valid), 32'd0);
        check("tmo_busy", 32'(busy), 32'd1);
        step();
        check("tmo_valid", 32'(out_valid), 32'd1);
        check("tmo_err", 32'(out_err), 32'd1);
        check("tmo_k", 32'(out_k), 32'd0);
        check("tmo_l", 32'(out_l), 32'd0);
        check("tmo_op_count", 32'(op_count), 32'd4);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        core_dead = 1'b0;
        check("tmo_release_valid", 32'(out_valid), 32'd0);

        // Recovery with a live core: k = -3+5+0-10 = -8, l = 10 + (-3*4) = -2.
        send(10, -3, 4, 0, 1, 1, 5);
        wait_valid("rec_valid", 3 * TIMEOUT);
        check("rec_err", 32'(out_err), 32'd0);
        check("rec_k", 32'(out_k), -32'sd8);
        check("rec_l", 32'(out_l), -32'sd2);
        check("rec_op_count", 32'(op_count), 32'd5);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;

        // op_count wrap: preload the counter while idle.
        dut.r_op_count = 16'hFFFF;
        #1;
        check("wrap_preload", 32'(op_count), 32'h0000_FFFF);
        send(2, 3, 4, 5, 2, 100, 7);
        wait_valid("wrap_valid", 3 * TIMEOUT);
        check("wrap_op_count", 32'(op_count), 32'd0);
        check("wrap_k", 32'(out_k), 32'd13);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("wrap_idle", 32'(in_ready), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
